imem_boot_loader: RTL

//   Upstream stage of the single-cycle CPU. Receives a length-prefixed byte stream
//   and assembles it into 32-bit instruction words, writing each word into the

---
 rtl/imem_boot_loader_if.sv | 11 +
 rtl/imem_boot_loader.sv | 105 ++++++++++
 2 files changed

// File: rtl/imem_boot_loader_if.sv
// imem_boot_loader_if: byte-stream input and instruction-memory write port of the boot loader.
interface imem_boot_loader_if #(parameter int ADDR_WIDTH = 8);
  logic [7:0] in_byte;
  logic in_valid;
  logic in_ready;
  logic imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0] imem_data;
  modport master(output in_byte, in_valid, input in_ready, imem_we, imem_addr, imem_data);
  modport slave(input in_byte, in_valid, output in_ready, imem_we, imem_addr, imem_data);
endinterface

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: assembles a length-prefixed byte stream into imem words, holding the CPU in reset until loaded.
module imem_boot_loader #(parameter int ADDR_WIDTH = 8) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  imem_boot_loader_if.slave bus,
  output logic cpu_reset_o,
  output logic done_o,
  output logic error_o,
  output logic [15:0] word_count_o
);
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, BYTES, WRITE, DONE, ERR} state_e;
  localparam logic [16:0] MAX_LEN = 17'(2 ** ADDR_WIDTH);
  state_e state_q, state_d;
  logic [15:0] len_q, len_d, wc_q, wc_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d, addr_q, addr_d;
  logic [1:0] bcnt_q, bcnt_d;
  logic [31:0] word_q, word_d, data_q, data_d;
  logic ready_q, ready_d, we_q, we_d, cpu_reset_q, cpu_reset_d;
  logic done_q, done_d, error_q, error_d;
  logic xfer, last;
  assign xfer = bus.in_valid & ready_q;
  assign last = (17'(idx_q) + 17'd1) == {1'b0, len_q};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      len_q <= '0;
      idx_q <= '0;
      bcnt_q <= '0;
      word_q <= '0;
      ready_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      cpu_reset_q <= 1'b1;
      done_q <= 1'b0;
      error_q <= 1'b0;
      wc_q <= '0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      idx_q <= idx_d;
      bcnt_q <= bcnt_d;
      word_q <= word_d;
      ready_q <= ready_d;
      we_q <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
      cpu_reset_q <= cpu_reset_d;
      done_q <= done_d;
      error_q <= error_d;
      wc_q <= wc_d;
    end
  always_comb begin
    state_d = state_q;
    len_d = len_q;
    idx_d = idx_q;
    bcnt_d = bcnt_q;
    word_d = word_q;
    case (state_q)
      IDLE, DONE, ERR: if (start_i) state_d = LEN_LO;
      LEN_LO: if (xfer) begin
        len_d[7:0] = bus.in_byte;
        state_d = LEN_HI;
      end
      LEN_HI: if (xfer) begin
        len_d[15:8] = bus.in_byte;
        idx_d = '0;
        bcnt_d = '0;
        state_d = (len_d == 16'd0) ? DONE : ({1'b0, len_d} > MAX_LEN) ? ERR : BYTES;
      end
      BYTES: if (xfer) begin
        word_d[{bcnt_q, 3'b000} +: 8] = bus.in_byte;
        bcnt_d = bcnt_q + 2'd1;
        state_d = (bcnt_q == 2'd3) ? WRITE : BYTES;
      end
      WRITE: if (last) state_d = DONE;
      else begin
        idx_d = idx_q + 1'b1;
        bcnt_d = '0;
        state_d = BYTES;
      end
      default: state_d = IDLE;
    endcase
  end
  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    ready_d = state_d inside {LEN_LO, LEN_HI, BYTES};
    we_d = state_d == WRITE;
    addr_d = we_d ? idx_q : addr_q;
    data_d = we_d ? word_d : data_q;
    cpu_reset_d = state_d != DONE;
    done_d = state_d == DONE;
    error_d = state_d == ERR;
    wc_d = (start_i && state_q inside {IDLE, DONE, ERR}) ? 16'd0 : wc_q + 16'(we_d);
  end
  assign bus.in_ready = ready_q;
  assign bus.imem_we = we_q;
  assign bus.imem_addr = addr_q;
  assign bus.imem_data = data_q;
  assign cpu_reset_o = cpu_reset_q;
  assign done_o = done_q;
  assign error_o = error_q;
  assign word_count_o = wc_q;
endmodule
